// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: 8x8 unsigned multiply sequenced over a shared 4x4 multiplier; MULT_SEQ_ZERO_SKIP_EN skips zero-nibble steps
module mult_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  operand_a,
  input  logic [7:0]  operand_b,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  input  logic [8:0]  mul_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        busy,
  output logic [15:0] done_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [7:0] a_r, b_r;
  logic [15:0] acc, cnt;
  logic [1:0] step;
  logic [2:0] nxt;
  logic unused_p;
`ifdef MULT_SEQ_ZERO_SKIP_EN
  localparam logic [3:0] FORCE = 4'h0;
`else
  localparam logic [3:0] FORCE = 4'hf;
`endif
  function automatic logic [3:0] qual(input logic [7:0] x, input logic [7:0] y);
    return FORCE | {|x[7:4] & |y[7:4], |x[3:0] & |y[7:4], |x[7:4] & |y[3:0], |x[3:0] & |y[3:0]};
  endfunction
  // {found, index} of the lowest enabled step at or after 'from'
  function automatic logic [2:0] pick(input logic [3:0] m, input logic [2:0] from);
    pick = 3'b000;
    for (int i = 3; i >= 0; i--) if (3'(i) >= from && m[i]) pick = {1'b1, 2'(i)};
  endfunction
  assign nxt = state == IDLE ? pick(qual(operand_a, operand_b), 3'd0) : pick(qual(a_r, b_r), 3'(step) + 3'd1);
  always_comb begin
    state_n = state;
    if (state == IDLE && in_valid) state_n = nxt[2] ? RUN : DONE;
    else if (state == RUN && !nxt[2]) state_n = DONE;
    else if (state == DONE && out_ready) state_n = IDLE;
  end
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign out_valid = state == DONE;
  assign result = acc;
  assign done_cnt = cnt;
  assign mul_a = state == RUN ? (step[0] ? a_r[7:4] : a_r[3:0]) : 4'd0;
  assign mul_b = state == RUN ? (step[1] ? b_r[7:4] : b_r[3:0]) : 4'd0;
  assign unused_p = mul_p[8];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      step <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        a_r <= operand_a;
        b_r <= operand_b;
        acc <= '0;
        step <= nxt[1:0];
      end
      if (state == RUN) begin
        acc <= acc + (16'(mul_p[7:0]) << {step[1] & step[0], step[1] ^ step[0], 2'b00});
        step <= nxt[1:0];
      end
      if (state == DONE && out_ready) cnt <= cnt + 16'd1;
    end
  end
endmodule
